// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: character-FSM state
// encoding, the default bit period and a counter-width helper.
// Optional parity checking is enabled with UART_FRAME_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  // 50 MHz system clock at 9600 baud
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Width of a counter that runs 0 .. n-1 (n = TIMEOUT_BITS*CLKS_PER_BIT)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Character receiver: 2-flop rx synchroniser plus start/data/stop FSM.
// Produces a registered byte strobe/data and framing-error pulse, and
// combinational per-cycle events that the frame assembler consumes.
// With UART_FRAME_RX_PARITY_EN an even-parity bit follows the data bits.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | timing to mid start bit, rejects glitches
// DATA      | sampling data bits mid-bit, LSB first
// PARITY    | sampling the parity bit (parity build only)
// STOP      | sampling the stop bit
// WAIT_HIGH | after a bad character, wait for the line to return high
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 framing_error,
  output logic                 busy,
  output logic                 idle,
  output logic                 start_det,
  output logic                 char_done,
  output logic                 char_bad,
  output logic [DATA_BITS-1:0] char_data
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta, rx_s;
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;

`ifdef UART_FRAME_RX_PARITY_EN
  logic par_bad, par_bad_nxt;
`else
  logic par_bad;
  assign par_bad = 1'b0;
`endif

  assign busy      = (state == DATA) || (state == PARITY) || (state == STOP);
  assign idle      = (state == IDLE);
  assign char_data = shreg;

  // Synchroniser, preset to the idle-high line level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Next-state, counters and per-character events
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    start_det = 1'b0;
    char_done = 1'b0;
    char_bad  = 1'b0;
`ifdef UART_FRAME_RX_PARITY_EN
    par_bad_nxt = par_bad;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_FRAME_RX_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          bit_nxt   = bit_idx + BIT_W'(1);
          if (bit_idx == LAST_BIT) begin
`ifdef UART_FRAME_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_FRAME_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
          // even parity: data plus parity bit must hold an even number of ones
          if (^{rx_s, shreg}) begin
            par_bad_nxt = 1'b1;
            char_bad    = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (par_bad) begin
            state_nxt = WAIT_HIGH;
          end else if (rx_s) begin
            char_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            char_bad  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered character outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_valid    <= 1'b0;
      byte_data     <= '0;
      framing_error <= 1'b0;
`ifdef UART_FRAME_RX_PARITY_EN
      par_bad       <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_idx       <= bit_nxt;
      shreg         <= shreg_nxt;
      byte_valid    <= char_done;
      framing_error <= char_bad;
      if (char_done) byte_data <= shreg;
`ifdef UART_FRAME_RX_PARITY_EN
      par_bad       <= par_bad_nxt;
`endif
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver top: assembles FRAME_BYTES characters into one
// command frame (first character in the most-significant slot) and drops
// a partial frame after TIMEOUT_BITS idle bit-times.
// Optional parity checking is enabled with UART_FRAME_RX_PARITY_EN.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int FRAME_BYTES  = 2,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             rx,
  output logic                             byteValid,
  output logic [DATA_BITS-1:0]             byteData,
  output logic                             frameValid,
  output logic [FRAME_BYTES*DATA_BITS-1:0] frameData,
  output logic                             framingError,
  output logic                             timeoutError,
  output logic                             busy
);

  localparam int FRAME_W = FRAME_BYTES * DATA_BITS;
  localparam int IDX_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TOUT    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TCNT_W  = cnt_width(TOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [TCNT_W-1:0] TOUT_LAST = TCNT_W'(TOUT - 1);

  logic                 smp_idle, start_det, char_done, char_bad;
  logic [DATA_BITS-1:0] char_data;
  logic [IDX_W-1:0]     idx;
  logic [TCNT_W-1:0]    tcnt;
  logic [FRAME_W-1:0]   shadow, frame_next;
  logic                 timeout_hit;

  uart_bit_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_sampler (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .byte_valid    (byteValid),
    .byte_data     (byteData),
    .framing_error (framingError),
    .busy          (busy),
    .idle          (smp_idle),
    .start_det     (start_det),
    .char_done     (char_done),
    .char_bad      (char_bad),
    .char_data     (char_data)
  );

  // Timeout wins over a start edge in the same cycle: the new character
  // then lands in slot 0 of a fresh frame.
  assign timeout_hit = smp_idle && (idx != '0) && (tcnt == TOUT_LAST);

  // Shadow frame with the incoming character dropped into its slot
  always_comb begin
    frame_next = shadow;
    for (int b = 0; b < FRAME_BYTES; b++) begin
      if (idx == IDX_W'(FRAME_BYTES - 1 - b))
        frame_next[b*DATA_BITS +: DATA_BITS] = char_data;
    end
  end

  // Frame index, shadow assembly and frame/timeout strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      shadow       <= '0;
      frameData    <= '0;
      frameValid   <= 1'b0;
      timeoutError <= 1'b0;
    end else begin
      frameValid   <= 1'b0;
      timeoutError <= 1'b0;
      if (char_bad) begin
        idx <= '0;
      end else if (char_done) begin
        shadow <= frame_next;
        if (idx == LAST_IDX) begin
          idx        <= '0;
          frameData  <= frame_next;
          frameValid <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else if (timeout_hit) begin
        idx          <= '0;
        timeoutError <= 1'b1;
      end
    end
  end

  // Inter-character idle timer, only runs with a partial frame pending
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (timeout_hit || start_det) begin
      tcnt <= '0;
    end else if (smp_idle && (idx != '0)) begin
      tcnt <= tcnt + TCNT_W'(1);
    end
  end

endmodule
